bht_ctrl: RTL and testbench
===========================

# bht_ctrl

Sequencing controller for the branch history table. It runs a post-reset or on-demand initialization sweep over all BHT entries. It converts execute-stage branch resolutions into BHT write commands using a 2-bit saturating-counter update. It detects mispredictions and issues the fetch flush/redirect, and it keeps saturating branch and miss performance counters. It sits between the execute stage and the BHT write port, and drives the fetch-stall line while the table is invalid.

## Interface
Parameters:
- IDX_W, 8, BHT index width (entries = 2**IDX_W)
- TAG_W, 22, BHT tag width (pc[31:IDX_W+2])

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- bht_clear  in  1  synchronous request to re-run the init sweep
- ex_valid  in  1  execute stage holds a resolved conditional branch
- ex_pc  in  32  PC of that branch
- ex_taken  in  1  actual outcome
- ex_pred  in  2  counter value used at fetch (carried down the pipe)
- ex_target  in  32  computed branch target
- bht_write  out  1  BHT write enable
- bht_widx  out  IDX_W  write index
- bht_wtag  out  TAG_W  write tag
- bht_wctr  out  2  write counter value
- init_busy  out  1  table invalid; fetch must stall and ignore predictions
- flush  out  1  misprediction; kill younger instructions
- redirect_pc  out  32  fetch restart PC, valid while flush=1
- br_count  out  32  resolved branches, saturating
- miss_count  out  32  mispredictions, saturating

## Operation
- FSM states: INIT, RUN. Reset state is INIT with init_idx=0.
- INIT behaviour:
  - Each cycle registers bht_write=1, bht_widx=init_idx, bht_wtag=0, bht_wctr=2'b01, then increments init_idx.
  - Once idx 2**IDX_W-1 has been issued, the FSM moves to RUN.
- bht_clear=1 in any state forces INIT with init_idx=0. Asserting it during INIT restarts the sweep.
- RUN, ex_valid=1: registers bht_write=1, bht_widx=ex_pc[IDX_W+1:2], bht_wtag=ex_pc[31:IDX_W+2], bht_wctr=sat(ex_pred, ex_taken).
  - taken: 11→11, otherwise +1.
  - not taken: 00→00, otherwise −1.
- RUN, ex_valid=0: bht_write=0. The other write fields hold their previous values.
- Misprediction is `ex_valid & (ex_pred[1] != ex_taken)`, evaluated in every state. Response:
  - registers flush=1.
  - redirect_pc = ex_target if ex_taken, else ex_pc+4 (32-bit wrap).
- Without a misprediction, flush=0 and redirect_pc holds.
- ex_valid in INIT: no BHT write, because the sweep write takes priority. flush and the counters still update.
- bht_clear together with ex_valid: clear wins for the write port. The resolve write is dropped, and flush and the counters still update.
- Performance counters:
  - br_count increments on every ex_valid.
  - miss_count increments on every misprediction.
  - Both hold at 32'hFFFF_FFFF.
  - Only rst clears them; bht_clear does not.

## Timing
- All outputs are registered. Reset values: bht_write=0, bht_widx=0, bht_wtag=0, bht_wctr=0, init_busy=1, flush=0, redirect_pc=0, br_count=0, miss_count=0.
- Init sweep after rst deasserts:
  - first edge: write idx 0.
  - edge k+1: write idx k.
  - idx 255 is presented after edge 256.
  - init_busy falls at edge 257, and RUN writes can appear from edge 257.
- Resolve to write/flush latency is 1 cycle. The controller issues one resolve per cycle, back-to-back, with no backpressure.
- flush is a single-cycle pulse per mispredicted branch. Consecutive mispredicting resolves give consecutive pulses, each carrying its own redirect_pc.
- Asserting rst mid-sweep or mid-update returns all state immediately to the reset values.

## Structure
- Package bp_pkg holds:
  - IDX_W/TAG_W defaults
  - ctr_t enum (SNT=00, WNT=01, WT=10, ST=11)
  - state enum {INIT, RUN}
  - function sat_update(ctr_t, logic taken)
- Sub-module bp_sat_cnt: 32-bit saturating increment counter with async reset. It is instanced twice, once for br_count and once for miss_count.

## Test plan
- Reset release: bht_write=1 for exactly 256 consecutive cycles, idx 0..255 in order with ctr=01 and tag=0; init_busy drops the cycle after idx 255.
- RUN, ex_valid with ex_pc=0x0000_1404, ex_pred=01, ex_taken=1, ex_target=0x0000_1000 → next cycle:
  - bht write: idx=0x01, tag=0x000005, ctr=10.
  - flush=1, redirect_pc=0x0000_1000, miss_count=1.
- Saturation and hit path:
  - ex_pred=11, taken=1 → ctr=11, flush=0.
  - ex_pred=00, taken=0 → ctr=00, flush=0.
  - ex_pred=10, taken=0 → ctr=01, flush=1, redirect_pc=ex_pc+4.
- bht_clear asserted with a mispredicting ex_valid in RUN → no resolve write, flush=1, sweep restarts at idx 0, init_busy=1; br_count preserved.
- Counters preloaded near 32'hFFFF_FFFE; 3 mispredicts → both counters hold at 32'hFFFF_FFFF.
- rst asserted asynchronously at sweep idx 100 → outputs go to reset values at once; the sweep restarts from idx 0 after release.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-history-table controller:
// counter encoding, controller states and the 2-bit saturating update.
package bp_pkg;

  localparam int IDX_W_DEF = 8;
  localparam int TAG_W_DEF = 22;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
    ctr_t res;
    case (ctr)
      SNT:     res = taken ? WNT : SNT;
      WNT:     res = taken ? WT  : SNT;
      WT:      res = taken ? ST  : WNT;
      ST:      res = taken ? ST  : WT;
      default: res = WNT;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module bp_sat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] cnt_r;

  // Count increment events, holding at the maximum value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 32'd0;
    end else if (inc && (cnt_r != 32'hFFFF_FFFF)) begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/bht_ctrl.sv
// BHT sequencing controller: init sweep, resolve-to-write conversion,
// misprediction flush/redirect and saturating performance counters.
module bht_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bht_clear,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [1:0]       ex_pred,
  input  logic [31:0]      ex_target,
  output logic             bht_write,
  output logic [IDX_W-1:0] bht_widx,
  output logic [TAG_W-1:0] bht_wtag,
  output logic [1:0]       bht_wctr,
  output logic             init_busy,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      br_count,
  output logic [31:0]      miss_count
);

  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  state_t           state_r, state_s;
  logic [IDX_W-1:0] init_idx_r, init_idx_s;
  logic             mispred_s;
  logic             wr_s;
  logic [IDX_W-1:0] widx_s;
  logic [TAG_W-1:0] wtag_s;
  logic [1:0]       wctr_s;
  logic [31:0]      redirect_s;
  logic             bht_write_r, init_busy_r, flush_r;
  logic [IDX_W-1:0] bht_widx_r;
  logic [TAG_W-1:0] bht_wtag_r;
  logic [1:0]       bht_wctr_r;
  logic [31:0]      redirect_pc_r;
  logic             pc_lsb_unused_s;

  assign pc_lsb_unused_s = ^ex_pc[1:0];
  assign mispred_s       = ex_valid & (ex_pred[1] != ex_taken);

  // Sweep sequencing: clear restarts the sweep from any state
  always_comb begin
    state_s    = state_r;
    init_idx_s = init_idx_r;
    if (bht_clear) begin
      state_s    = INIT;
      init_idx_s = IDX_ZERO;
    end else begin
      case (state_r)
        INIT: begin
          init_idx_s = init_idx_r + IDX_ONE;
          if (init_idx_r == IDX_LAST) begin
            state_s = RUN;
          end else begin
            state_s = INIT;
          end
        end
        RUN:     state_s = RUN;
        default: begin
          state_s    = INIT;
          init_idx_s = IDX_ZERO;
        end
      endcase
    end
  end

  // Write-port selection: clear, then sweep, then resolve; idle holds fields
  always_comb begin
    wr_s   = 1'b0;
    widx_s = bht_widx_r;
    wtag_s = bht_wtag_r;
    wctr_s = bht_wctr_r;
    if (bht_clear) begin
      wr_s = 1'b0;
    end else if (state_r == INIT) begin
      wr_s   = 1'b1;
      widx_s = init_idx_r;
      wtag_s = {TAG_W{1'b0}};
      wctr_s = WNT;
    end else if (ex_valid) begin
      wr_s   = 1'b1;
      widx_s = ex_pc[IDX_W+1:2];
      wtag_s = ex_pc[31:IDX_W+2];
      wctr_s = sat_update(ctr_t'(ex_pred), ex_taken);
    end else begin
      wr_s = 1'b0;
    end
  end

  // Restart address for a mispredicted branch
  always_comb begin
    redirect_s = redirect_pc_r;
    if (mispred_s) begin
      redirect_s = ex_taken ? ex_target : (ex_pc + 32'd4);
    end else begin
      redirect_s = redirect_pc_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= INIT;
      init_idx_r    <= IDX_ZERO;
      bht_write_r   <= 1'b0;
      bht_widx_r    <= IDX_ZERO;
      bht_wtag_r    <= {TAG_W{1'b0}};
      bht_wctr_r    <= 2'b00;
      init_busy_r   <= 1'b1;
      flush_r       <= 1'b0;
      redirect_pc_r <= 32'd0;
    end else begin
      state_r       <= state_s;
      init_idx_r    <= init_idx_s;
      bht_write_r   <= wr_s;
      bht_widx_r    <= widx_s;
      bht_wtag_r    <= wtag_s;
      bht_wctr_r    <= wctr_s;
      init_busy_r   <= bht_clear | (state_r == INIT);
      flush_r       <= mispred_s;
      redirect_pc_r <= redirect_s;
    end
  end

  bp_sat_cnt u_br_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ex_valid),
    .cnt (br_count)
  );

  bp_sat_cnt u_miss_cnt (
    .clk (clk),
    .rst (rst),
    .inc (mispred_s),
    .cnt (miss_count)
  );

  assign bht_write   = bht_write_r;
  assign bht_widx    = bht_widx_r;
  assign bht_wtag    = bht_wtag_r;
  assign bht_wctr    = bht_wctr_r;
  assign init_busy   = init_busy_r;
  assign flush       = flush_r;
  assign redirect_pc = redirect_pc_r;

endmodule

// File: tb/tb_bht_ctrl.sv
// Directed scoreboard bench for bht_ctrl: each driven cycle pushes the
// expected registered outputs, which are popped and checked after the edge.
module tb_bht_ctrl;

  logic        clk = 1'b0;
  logic        rst, bht_clear, ex_valid, ex_taken;
  logic [31:0] ex_pc, ex_target;
  logic [1:0]  ex_pred;
  logic        bht_write, init_busy, flush;
  logic [7:0]  bht_widx;
  logic [21:0] bht_wtag;
  logic [1:0]  bht_wctr;
  logic [31:0] redirect_pc, br_count, miss_count;

  typedef struct {
    logic        wr;
    logic [7:0]  widx;
    logic [21:0] wtag;
    logic [1:0]  wctr;
    logic        busy;
    logic        flush;
    logic [31:0] redir;
    logic [31:0] br;
    logic [31:0] miss;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  bit          m_init;
  int          m_idx;
  logic [7:0]  m_widx;
  logic [21:0] m_wtag;
  logic [1:0]  m_wctr;
  logic [31:0] m_redir, m_br, m_miss;

  bht_ctrl #(.IDX_W(8), .TAG_W(22)) dut (
    .clk(clk), .rst(rst), .bht_clear(bht_clear), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_pred(ex_pred), .ex_target(ex_target),
    .bht_write(bht_write), .bht_widx(bht_widx), .bht_wtag(bht_wtag),
    .bht_wctr(bht_wctr), .init_busy(init_busy), .flush(flush),
    .redirect_pc(redirect_pc), .br_count(br_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1; m_idx = 0;
    m_widx = 8'h00; m_wtag = 22'h0; m_wctr = 2'b00;
    m_redir = 32'h0; m_br = 32'h0; m_miss = 32'h0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".write"}, 32'(bht_write), 32'h0);
    chk({tag, ".widx"},  32'(bht_widx), 32'h0);
    chk({tag, ".wtag"},  32'(bht_wtag), 32'h0);
    chk({tag, ".wctr"},  32'(bht_wctr), 32'h0);
    chk({tag, ".busy"},  32'(init_busy), 32'h1);
    chk({tag, ".flush"}, 32'(flush), 32'h0);
    chk({tag, ".redir"}, redirect_pc, 32'h0);
    chk({tag, ".br"},    br_count, 32'h0);
    chk({tag, ".miss"},  miss_count, 32'h0);
  endtask

  // Apply one cycle of stimulus and queue the outputs expected after the edge
  task automatic drive(input logic clr, input logic v, input logic tk,
                       input logic [1:0] pr, input logic [31:0] pc, input logic [31:0] tgt);
    exp_t e;
    int   p;
    logic mis;
    bht_clear = clr; ex_valid = v; ex_taken = tk; ex_pred = pr;
    ex_pc = pc; ex_target = tgt;
    mis    = v && (pr[1] ^ tk);
    e.busy = clr || m_init;
    if (clr) begin
      e.wr = 1'b0; m_init = 1'b1; m_idx = 0;
    end else if (m_init) begin
      e.wr = 1'b1; m_widx = m_idx[7:0]; m_wtag = 22'h0; m_wctr = 2'b01;
      m_idx++;
      if (m_idx == 256) m_init = 1'b0;
    end else if (v) begin
      e.wr = 1'b1; m_widx = pc[9:2]; m_wtag = pc[31:10];
      p = int'(pr);
      p = tk ? ((p < 3) ? p + 1 : 3) : ((p > 0) ? p - 1 : 0);
      m_wctr = p[1:0];
    end else begin
      e.wr = 1'b0;
    end
    if (mis) m_redir = tk ? tgt : pc + 32'd4;
    if (v && m_br != 32'hFFFF_FFFF) m_br = m_br + 32'd1;
    if (mis && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
    e.widx = m_widx; e.wtag = m_wtag; e.wctr = m_wctr; e.flush = mis;
    e.redir = m_redir; e.br = m_br; e.miss = m_miss;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  // Advance one edge and compare the DUT against the oldest expectation
  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".write"}, 32'(bht_write), 32'(e.wr));
    chk({tag, ".widx"},  32'(bht_widx), 32'(e.widx));
    chk({tag, ".wtag"},  32'(bht_wtag), 32'(e.wtag));
    chk({tag, ".wctr"},  32'(bht_wctr), 32'(e.wctr));
    chk({tag, ".busy"},  32'(init_busy), 32'(e.busy));
    chk({tag, ".flush"}, 32'(flush), 32'(e.flush));
    chk({tag, ".redir"}, redirect_pc, e.redir);
    chk({tag, ".br"},    br_count, e.br);
    chk({tag, ".miss"},  miss_count, e.miss);
  endtask

  initial begin
    rst = 1'b1; bht_clear = 1'b0; ex_valid = 1'b0; ex_taken = 1'b0;
    ex_pred = 2'b00; ex_pc = 32'h0; ex_target = 32'h0;
    model_reset();
    #12;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) begin
      idle(); step("sweep");
    end
    idle(); step("sweep_end");
    chk("sweep_end.busy_low", 32'(init_busy), 32'h0);

    drive(1'b0, 1'b1, 1'b1, 2'b01, 32'h0000_1404, 32'h0000_1000); step("t1");
    chk("t1.idx", 32'(bht_widx), 32'h01);
    chk("t1.tag", 32'(bht_wtag), 32'h5);
    chk("t1.ctr", 32'(bht_wctr), 32'h2);
    chk("t1.redir", redirect_pc, 32'h0000_1000);
    chk("t1.miss", miss_count, 32'h1);

    drive(1'b0, 1'b1, 1'b1, 2'b11, 32'h0000_2008, 32'h0000_3000); step("sat_hi");
    chk("sat_hi.ctr", 32'(bht_wctr), 32'h3);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_200C, 32'h0000_3000); step("sat_lo");
    chk("sat_lo.ctr", 32'(bht_wctr), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_4010, 32'h0000_5000); step("wt_nt");
    chk("wt_nt.redir", redirect_pc, 32'h0000_4014);
    idle(); step("idle_hold");

    drive(1'b0, 1'b1, 1'b0, 2'b11, 32'hFFFF_FFFC, 32'h0000_0100); step("b2b_a");
    chk("b2b_a.wrap", redirect_pc, 32'h0000_0000);
    drive(1'b0, 1'b1, 1'b1, 2'b00, 32'h8000_0000, 32'h1234_5678); step("b2b_b");
    chk("b2b_b.redir", redirect_pc, 32'h1234_5678);

    drive(1'b1, 1'b1, 1'b0, 2'b11, 32'h0000_0600, 32'h0); step("clr");
    chk("clr.br_kept", br_count, 32'h7);
    for (int i = 0; i < 256; i++) begin
      if (i == 5) drive(1'b0, 1'b1, 1'b1, 2'b01, 32'h0000_0700, 32'h0000_0900);
      else idle();
      step("resweep");
    end
    idle(); step("resweep_end");

    bht_clear = 1'b0; ex_valid = 1'b0;
    force dut.u_br_cnt.cnt_r = 32'hFFFF_FFFE;
    force dut.u_miss_cnt.cnt_r = 32'hFFFF_FFFE;
    #1;
    release dut.u_br_cnt.cnt_r;
    release dut.u_miss_cnt.cnt_r;
    m_br = 32'hFFFF_FFFE; m_miss = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_0A00 + 32'(i * 4), 32'h0); step("cnt_sat");
    end
    chk("cnt_sat.br", br_count, 32'hFFFF_FFFF);
    chk("cnt_sat.miss", miss_count, 32'hFFFF_FFFF);

    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0); step("clr2");
    for (int i = 0; i <= 100; i++) begin
      idle(); step("sweep_to_100");
    end
    #2;
    rst = 1'b1;
    #1;
    check_reset("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(); step("after_rst");
    end
    chk("after_rst.idx", 32'(bht_widx), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
